// File: rtl/axi_master_pkg.sv
// Shared types and default widths for the AXI-Lite master slice.
package axi_lite_pkg;
  localparam int AXI_ADDR_W         = 4;
  localparam int AXI_DATA_W         = 8;
  localparam int AXI_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP} wr_state_t;
endpackage

// File: rtl/axi_master_if.sv
// AR/R and AW/W/B channel bundle between axi_master and axi_slave.
interface axi_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();
  logic [ADDR_W-1:0] read_address;
  logic              AR_VALID;
  logic              AR_READY;
  logic [DATA_W-1:0] data_read;
  logic              R_VALID;
  logic              R_READY;
  logic [ADDR_W-1:0] write_address;
  logic              AW_VALID;
  logic              AW_READY;
  logic [DATA_W-1:0] data_write;
  logic              W_VALID;
  logic              W_READY;
  logic              B_VALID;
  logic              B_READY;

  modport master (
    output read_address, AR_VALID, R_READY,
    output write_address, AW_VALID, data_write, W_VALID, B_READY,
    input  AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID
  );

  modport slave (
    input  read_address, AR_VALID, R_READY,
    input  write_address, AW_VALID, data_write, W_VALID, B_READY,
    output AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID
  );
endinterface

// File: rtl/axi_master_timeout_ctr.sv
// Stall counter for one FSM: restarts on every state change, flags when
// TIMEOUT_CYCLES cycles have elapsed in a wait state with no progress.
module axi_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic busy,
  output logic expired
);
  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles spent in the current wait state; saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !busy)      cnt_d = '0;
    else if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = busy && (cnt_q == LAST);
endmodule

// File: rtl/axi_master.sv
// AXI-Lite style master: independent read (AR/R) and write (AW/W/B) FSMs.
// Optional stall abort enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W         = AXI_ADDR_W,
  parameter int DATA_W         = AXI_DATA_W,
  parameter int TIMEOUT_CYCLES = AXI_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address_to_read,
  input  logic [ADDR_W-1:0] address_to_write,
  input  logic [DATA_W-1:0] data_to_write,
  output logic [DATA_W-1:0] data_being_read,
  output logic              timeout_err,
  axi_master_if.master      bus
);
  rd_state_t         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] read_address_q, read_address_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  wr_state_t         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_valid_q, aw_valid_d;
  logic              w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d;

  logic              timeout_err_q, timeout_err_d;
  logic              rd_abort, wr_abort;
  logic              rd_expired, wr_expired;
  logic              aw_fire, w_fire;

`ifdef AXI_MASTER_TIMEOUT_EN
  axi_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_ctr (
    .clk(clk), .rst(rst), .clr(rd_state_d != rd_state_q),
    .busy(rd_state_q != RD_IDLE), .expired(rd_expired)
  );
  axi_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_ctr (
    .clk(clk), .rst(rst), .clr(wr_state_d != wr_state_q),
    .busy(wr_state_q != WR_IDLE), .expired(wr_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign rd_expired = 1'b0;
  assign wr_expired = 1'b0;
`endif

  // Read FSM next state: AR issue, then wait for R beat.
  always_comb begin
    rd_state_d     = rd_state_q;
    read_address_d = read_address_q;
    ar_valid_d     = ar_valid_q;
    r_ready_d      = r_ready_q;
    rdata_d        = rdata_q;
    rd_abort       = 1'b0;
    case (rd_state_q)
      RD_IDLE: if (read) begin
        read_address_d = address_to_read;
        ar_valid_d     = 1'b1;
        rd_state_d     = RD_ADDR;
      end
      RD_ADDR: if (ar_valid_q && bus.AR_READY) begin
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b1;
        rd_state_d = RD_DATA;
      end else if (rd_expired) begin
        ar_valid_d = 1'b0;
        rd_abort   = 1'b1;
        rd_state_d = RD_IDLE;
      end
      RD_DATA: if (r_ready_q && bus.R_VALID) begin
        rdata_d    = bus.data_read;
        r_ready_d  = 1'b0;
        rd_state_d = RD_IDLE;
      end else if (rd_expired) begin
        r_ready_d  = 1'b0;
        rd_abort   = 1'b1;
        rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign aw_fire = aw_valid_q && bus.AW_READY;
  assign w_fire  = w_valid_q && bus.W_READY;

  // Write FSM next state: AW and W retire independently, then collect B.
  always_comb begin
    wr_state_d      = wr_state_q;
    write_address_d = write_address_q;
    wdata_d         = wdata_q;
    aw_valid_d      = aw_valid_q;
    w_valid_d       = w_valid_q;
    b_ready_d       = b_ready_q;
    wr_abort        = 1'b0;
    case (wr_state_q)
      WR_IDLE: if (write) begin
        write_address_d = address_to_write;
        wdata_d         = data_to_write;
        aw_valid_d      = 1'b1;
        w_valid_d       = 1'b1;
        wr_state_d      = WR_REQ;
      end
      WR_REQ: begin
        if (aw_fire) aw_valid_d = 1'b0;
        if (w_fire)  w_valid_d  = 1'b0;
        if ((!aw_valid_q || aw_fire) && (!w_valid_q || w_fire)) begin
          b_ready_d  = 1'b1;
          wr_state_d = WR_RESP;
        end else if (wr_expired) begin
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b0;
          wr_abort   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      WR_RESP: if (b_ready_q && bus.B_VALID) begin
        b_ready_d  = 1'b0;
        wr_state_d = WR_IDLE;
      end else if (wr_expired) begin
        b_ready_d  = 1'b0;
        wr_abort   = 1'b1;
        wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign timeout_err_d = rd_abort || wr_abort;

  // State and registered outputs for both FSMs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_q      <= RD_IDLE;
      read_address_q  <= '0;
      ar_valid_q      <= 1'b0;
      r_ready_q       <= 1'b0;
      rdata_q         <= '0;
      wr_state_q      <= WR_IDLE;
      write_address_q <= '0;
      wdata_q         <= '0;
      aw_valid_q      <= 1'b0;
      w_valid_q       <= 1'b0;
      b_ready_q       <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      rd_state_q      <= rd_state_d;
      read_address_q  <= read_address_d;
      ar_valid_q      <= ar_valid_d;
      r_ready_q       <= r_ready_d;
      rdata_q         <= rdata_d;
      wr_state_q      <= wr_state_d;
      write_address_q <= write_address_d;
      wdata_q         <= wdata_d;
      aw_valid_q      <= aw_valid_d;
      w_valid_q       <= w_valid_d;
      b_ready_q       <= b_ready_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign bus.read_address  = read_address_q;
  assign bus.AR_VALID      = ar_valid_q;
  assign bus.R_READY       = r_ready_q;
  assign bus.write_address = write_address_q;
  assign bus.AW_VALID      = aw_valid_q;
  assign bus.data_write    = wdata_q;
  assign bus.W_VALID       = w_valid_q;
  assign bus.B_READY       = b_ready_q;
  assign data_being_read   = rdata_q;
  assign timeout_err       = timeout_err_q;
endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master; the bench itself plays the slave.
// Timeout scenario is compiled in with AXI_MASTER_TIMEOUT_EN.
module tb_axi_master;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       read = 1'b0, write = 1'b0;
  logic [3:0] address_to_read = '0, address_to_write = '0;
  logic [7:0] data_to_write = '0;
  logic [7:0] data_being_read;
  logic       timeout_err;
  int         checks = 0;
  int         errors = 0;

  axi_master_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  axi_master #(.ADDR_W(4), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write),
    .address_to_read(address_to_read), .address_to_write(address_to_write),
    .data_to_write(data_to_write), .data_being_read(data_being_read),
    .timeout_err(timeout_err), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    bus.AR_READY = 1'b0; bus.R_VALID = 1'b0; bus.data_read = '0;
    bus.AW_READY = 1'b0; bus.W_READY = 1'b0; bus.B_VALID = 1'b0;
  endtask

  task automatic test_reset();
    // complete one read so data_being_read is non-zero
    bus.AR_READY = 1'b1; bus.R_VALID = 1'b1; bus.data_read = 8'h5A;
    address_to_read = 4'h9; read = 1'b1;
    tick(); read = 1'b0;
    tick(); tick();
    checks++; if (data_being_read !== 8'h5A) begin errors++; $display("FAIL rst_preread: got %h exp 5a", data_being_read); end
    // start another read and stall it, then reset mid-flight
    slave_idle();
    read = 1'b1; tick(); read = 1'b0; tick();
    checks++; if (bus.AR_VALID !== 1'b1) begin errors++; $display("FAIL rst_midread_arvalid: got %b exp 1", bus.AR_VALID); end
    rst = 1'b0; tick(); tick();
    checks++; if (bus.AR_VALID !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b exp 0", bus.AR_VALID); end
    checks++; if (bus.R_READY !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b exp 0", bus.R_READY); end
    checks++; if ({bus.AW_VALID, bus.W_VALID, bus.B_READY} !== 3'b000) begin errors++; $display("FAIL rst_wr_ctrl: got %b exp 000", {bus.AW_VALID, bus.W_VALID, bus.B_READY}); end
    checks++; if (data_being_read !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", data_being_read); end
    checks++; if (bus.read_address !== 4'h0) begin errors++; $display("FAIL rst_raddr: got %h exp 0", bus.read_address); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b exp 0", timeout_err); end
    rst = 1'b1; bus.AR_READY = 1'b1; tick();
    checks++; if (bus.AR_VALID !== 1'b0) begin errors++; $display("FAIL rst_idle_after: got %b exp 0", bus.AR_VALID); end
    slave_idle();
  endtask

  task automatic test_read();
    bus.AR_READY = 1'b1; bus.R_VALID = 1'b1; bus.data_read = 8'hA5;
    address_to_read = 4'h5; read = 1'b1;
    tick(); read = 1'b0;
    checks++; if (bus.AR_VALID !== 1'b1 || bus.read_address !== 4'h5) begin errors++; $display("FAIL read_ar: got v=%b a=%h exp v=1 a=5", bus.AR_VALID, bus.read_address); end
    checks++; if (bus.R_READY !== 1'b0) begin errors++; $display("FAIL read_rready_early: got %b exp 0", bus.R_READY); end
    tick();
    checks++; if (bus.AR_VALID !== 1'b0 || bus.R_READY !== 1'b1) begin errors++; $display("FAIL read_phase2: got arv=%b rr=%b exp 0 1", bus.AR_VALID, bus.R_READY); end
    checks++; if (data_being_read !== 8'h00) begin errors++; $display("FAIL read_data_early: got %h exp 00", data_being_read); end
    tick();
    checks++; if (data_being_read !== 8'hA5) begin errors++; $display("FAIL read_data: got %h exp a5", data_being_read); end
    checks++; if (bus.R_READY !== 1'b0) begin errors++; $display("FAIL read_rready_done: got %b exp 0", bus.R_READY); end
    slave_idle();
  endtask

  task automatic test_write();
    address_to_write = 4'h5; data_to_write = 8'hAA; write = 1'b1;
    tick(); write = 1'b0;
    checks++; if ({bus.AW_VALID, bus.W_VALID} !== 2'b11) begin errors++; $display("FAIL write_valids: got %b exp 11", {bus.AW_VALID, bus.W_VALID}); end
    checks++; if (bus.write_address !== 4'h5 || bus.data_write !== 8'hAA) begin errors++; $display("FAIL write_payload: got a=%h d=%h exp 5 aa", bus.write_address, bus.data_write); end
    bus.AW_READY = 1'b1; tick();
    checks++; if ({bus.AW_VALID, bus.W_VALID} !== 2'b01) begin errors++; $display("FAIL write_aw_first: got %b exp 01", {bus.AW_VALID, bus.W_VALID}); end
    bus.AW_READY = 1'b0; bus.W_READY = 1'b1; tick();
    checks++; if ({bus.W_VALID, bus.B_READY} !== 2'b01) begin errors++; $display("FAIL write_w_done: got %b exp 01", {bus.W_VALID, bus.B_READY}); end
    bus.W_READY = 1'b0; tick();
    checks++; if (bus.B_READY !== 1'b1) begin errors++; $display("FAIL write_bready_hold: got %b exp 1", bus.B_READY); end
    bus.B_VALID = 1'b1; tick();
    checks++; if (bus.B_READY !== 1'b0) begin errors++; $display("FAIL write_bready_drop: got %b exp 0", bus.B_READY); end
    checks++; if (bus.write_address !== 4'h5 || bus.data_write !== 8'hAA) begin errors++; $display("FAIL write_hold_idle: got a=%h d=%h exp 5 aa", bus.write_address, bus.data_write); end
    slave_idle();
  endtask

  task automatic test_stall();
    address_to_read = 4'h5; read = 1'b1;
    tick(); read = 1'b0; address_to_read = 4'h7;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.AR_VALID !== 1'b1 || bus.read_address !== 4'h5) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b a=%h exp 1 5", i, bus.AR_VALID, bus.read_address); end
    end
    bus.AR_READY = 1'b1; bus.R_VALID = 1'b1; bus.data_read = 8'h77;
    tick();
    checks++; if (bus.AR_VALID !== 1'b0 || bus.R_READY !== 1'b1) begin errors++; $display("FAIL stall_ar_done: got arv=%b rr=%b exp 0 1", bus.AR_VALID, bus.R_READY); end
    tick();
    checks++; if (data_being_read !== 8'h77) begin errors++; $display("FAIL stall_data: got %h exp 77", data_being_read); end
    slave_idle();
  endtask

  task automatic test_concurrency();
    address_to_read = 4'h3; read = 1'b1;
    address_to_write = 4'h5; data_to_write = 8'h3C; write = 1'b1;
    tick(); read = 1'b0; write = 1'b0;
    checks++; if ({bus.AR_VALID, bus.AW_VALID, bus.W_VALID} !== 3'b111) begin errors++; $display("FAIL conc_valids: got %b exp 111", {bus.AR_VALID, bus.AW_VALID, bus.W_VALID}); end
    checks++; if (bus.read_address !== 4'h3 || bus.write_address !== 4'h5 || bus.data_write !== 8'h3C) begin errors++; $display("FAIL conc_payload: got ra=%h wa=%h wd=%h exp 3 5 3c", bus.read_address, bus.write_address, bus.data_write); end
    address_to_read = 4'hE; read = 1'b1;
    tick(); read = 1'b0;
    checks++; if (bus.AR_VALID !== 1'b1 || bus.read_address !== 4'h3) begin errors++; $display("FAIL conc_busy_ignore: got v=%b a=%h exp 1 3", bus.AR_VALID, bus.read_address); end
    bus.AR_READY = 1'b1; bus.AW_READY = 1'b1; bus.W_READY = 1'b1;
    bus.R_VALID = 1'b1; bus.data_read = 8'hC3; bus.B_VALID = 1'b1;
    tick();
    checks++; if ({bus.AR_VALID, bus.AW_VALID, bus.W_VALID, bus.R_READY, bus.B_READY} !== 5'b00011) begin errors++; $display("FAIL conc_phase2: got %b exp 00011", {bus.AR_VALID, bus.AW_VALID, bus.W_VALID, bus.R_READY, bus.B_READY}); end
    tick();
    checks++; if (data_being_read !== 8'hC3 || bus.R_READY !== 1'b0 || bus.B_READY !== 1'b0) begin errors++; $display("FAIL conc_done: got d=%h rr=%b br=%b exp c3 0 0", data_being_read, bus.R_READY, bus.B_READY); end
    tick();
    checks++; if (bus.AR_VALID !== 1'b0) begin errors++; $display("FAIL conc_not_queued: got %b exp 0", bus.AR_VALID); end
    slave_idle();
  endtask

`ifdef AXI_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    address_to_write = 4'h2; data_to_write = 8'h11; write = 1'b1;
    tick(); write = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    checks++; if ({bus.AW_VALID, bus.W_VALID, timeout_err} !== 3'b110) begin errors++; $display("FAIL timeout_before: got %b exp 110", {bus.AW_VALID, bus.W_VALID, timeout_err}); end
    tick();
    checks++; if ({bus.AW_VALID, bus.W_VALID, timeout_err} !== 3'b001) begin errors++; $display("FAIL timeout_abort: got %b exp 001", {bus.AW_VALID, bus.W_VALID, timeout_err}); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b exp 0", timeout_err); end
    slave_idle();
  endtask
`endif

  initial begin
    slave_idle();
    tick(); tick();
    rst = 1'b1;
    tick();
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_concurrency();
`ifdef AXI_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
